// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode constants and sequencer state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W = 12;

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpStore = 4'b0010;
    localparam logic [3:0] OpLoad  = 4'b0011;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpOr    = 4'b0110;
    localparam logic [3:0] OpXor   = 4'b0111;
    localparam logic [3:0] OpNot   = 4'b1000;
    localparam logic [3:0] OpShl   = 4'b1001;
    localparam logic [3:0] OpHalt  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } seq_state_e;

    function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] word);
        return word[11:8];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-load and instruction-issue bus between the sequencer and its controller / CPU core.
interface instr_sequencer_if;
    import cpu_pkg::*;

    logic               ena;
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_ready;
    logic               prog_clr;
    logic               start;
    logic               halt_req;
    logic               issue_valid;
    logic [3:0]         issue_opcode;
    logic [3:0]         issue_data;
    logic [3:0]         issue_addr;
    logic               issue_we;
    logic [3:0]         pc;
    logic               busy;
    logic               done;

    modport slave (
        input  ena, load_valid, load_data, prog_clr, start, halt_req,
        output load_ready, issue_valid, issue_opcode, issue_data, issue_addr, issue_we,
               pc, busy, done
    );

    modport master (
        output ena, load_valid, load_data, prog_clr, start, halt_req,
        input  load_ready, issue_valid, issue_opcode, issue_data, issue_addr, issue_we,
               pc, busy, done
    );

endinterface

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x INSTR_W register file, one write port, one asynchronous read port.
module seq_prog_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [INSTR_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INSTR_W-1:0]       rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a program, then issues one instruction every ISSUE_GAP cycles.
// Define INSTR_SEQUENCER_LOOP_EN to wrap from the last instruction back to pc 0.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ISSUE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_sequencer_if.slave bus
);

    localparam int unsigned AddrW   = $clog2(DEPTH);
    localparam int unsigned GapW    = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP - 1) : 1;
    localparam logic [4:0]  DepthW  = 5'(DEPTH);
    localparam logic [GapW-1:0] GapLast = GapW'(ISSUE_GAP - 2);

    seq_state_e         state_q, state_d;
    logic [3:0]         pc_q, pc_d;
    logic [4:0]         wr_ptr_q, wr_ptr_d;
    logic [4:0]         prog_len_q, prog_len_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic               halt_q, halt_d;
    logic               mem_we;
    logic               load_ok;
    logic               last_instr;
    logic               halt_now;
    logic               halt_op;
    logic [INSTR_W-1:0] rd_word;
    logic [INSTR_W-1:0] issue_word;

    seq_prog_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (mem_we),
        .waddr(wr_ptr_q[AddrW-1:0]),
        .wdata(bus.load_data),
        .raddr(pc_q[AddrW-1:0]),
        .rdata(rd_word)
    );

    assign load_ok    = (state_q == StIdle) && (wr_ptr_q < DepthW);
    assign last_instr = ({1'b0, pc_q} == (prog_len_q - 5'd1));
    assign halt_now   = halt_q | bus.halt_req;
    assign halt_op    = (instr_opcode(rd_word) == OpHalt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            gap_q      <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            gap_q      <= gap_d;
            halt_q     <= halt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        gap_d      = gap_q;
        halt_d     = halt_q;
        mem_we     = 1'b0;

        // Disabled cycles discard every input and leave all state untouched.
        if (bus.ena) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.load_valid) begin
                        if (load_ok) begin
                            mem_we     = 1'b1;
                            wr_ptr_d   = wr_ptr_q + 5'd1;
                            prog_len_d = wr_ptr_q + 5'd1;
                        end
                    end else if (bus.prog_clr) begin
                        wr_ptr_d   = '0;
                        prog_len_d = '0;
                    end else if (bus.start && (prog_len_q != 5'd0)) begin
                        state_d = StIssue;
                        pc_d    = '0;
                        halt_d  = 1'b0;
                    end
                end
                StIssue: begin
                    state_d = StWait;
                    gap_d   = '0;
                    halt_d  = halt_now;
                end
                StWait: begin
                    halt_d = halt_now;
                    if (gap_q != GapLast) begin
                        gap_d = gap_q + 1'b1;
                    end else begin
`ifdef INSTR_SEQUENCER_LOOP_EN
                        if (halt_op || halt_now) begin
                            state_d = StDone;
                            halt_d  = 1'b0;
                        end else begin
                            state_d = StIssue;
                            pc_d    = last_instr ? 4'd0 : pc_q + 4'd1;
                            halt_d  = 1'b0;
                        end
`else
                        if (halt_op || halt_now || last_instr) begin
                            state_d = StDone;
                            halt_d  = 1'b0;
                        end else begin
                            state_d = StIssue;
                            pc_d    = pc_q + 4'd1;
                            halt_d  = 1'b0;
                        end
`endif
                    end
                end
                StDone: begin
                    if (bus.start) begin
                        state_d = StIssue;
                        pc_d    = '0;
                        halt_d  = 1'b0;
                    end else if (bus.prog_clr) begin
                        state_d    = StIdle;
                        pc_d       = '0;
                        wr_ptr_d   = '0;
                        prog_len_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Issue fields are zero while idle so reset and loading never present a stale instruction.
    assign issue_word       = (state_q == StIdle) ? '0 : rd_word;
    assign bus.issue_opcode = issue_word[11:8];
    assign bus.issue_data   = issue_word[7:4];
    assign bus.issue_addr   = issue_word[3:0];
    assign bus.issue_we     = (issue_word[11:8] == OpStore);
    assign bus.issue_valid  = (state_q == StIssue);
    assign bus.busy         = (state_q == StIssue) || (state_q == StWait);
    assign bus.done         = (state_q == StDone);
    assign bus.pc           = pc_q;
    assign bus.load_ready   = load_ok;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer with a trace-level reference model of program execution.
module tb_instr_sequencer;
    import cpu_pkg::*;

    localparam int GAP   = 2;
    localparam int DEPTH = 16;
`ifdef INSTR_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    instr_sequencer_if bus ();

    instr_sequencer #(
        .DEPTH    (DEPTH),
        .ISSUE_GAP(GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] model_mem [DEPTH];
    int          model_len;
    int          model_wr;
    int          exp_pcs[$];
    logic [3:0]  op_pool [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] obs_vec();
        return {bus.issue_valid, bus.busy, bus.done, bus.issue_we, bus.pc,
                bus.issue_opcode, bus.issue_data, bus.issue_addr, bus.load_ready};
    endfunction

    task automatic chk_reset(input string tag);
        chk(tag, obs_vec(), 32'h1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_len = 0;
        model_wr  = 0;
    endtask

    function automatic logic [11:0] rand_word(input bit allow_halt);
        logic [3:0] op;
        op = op_pool[$urandom_range(0, allow_halt ? 9 : 8)];
        return {op, 8'($urandom)};
    endfunction

    task automatic do_load(input logic [11:0] w);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        chk("load_ready", bus.load_ready, (model_wr < DEPTH));
        if (model_wr < DEPTH) begin
            model_mem[model_wr] = w;
            model_wr++;
            model_len = model_wr;
        end
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.prog_clr = 1'b1;
        tick();
        bus.prog_clr = 1'b0;
        model_len = 0;
        model_wr  = 0;
        chk_reset("prog_clr");
    endtask

    // Sequence of pcs the program must issue, given the instruction index that sees halt_req.
    task automatic build_trace(input int halt_instr);
        int p;
        exp_pcs.delete();
        p = 0;
        for (int k = 0; k < 64; k++) begin
            exp_pcs.push_back(p);
            if (model_mem[p][11:8] == OpHalt || k == halt_instr) break;
            if (p == model_len - 1) begin
                if (!LOOP) break;
                p = 0;
            end else begin
                p++;
            end
        end
    endtask

    function automatic logic [20:0] exp_vec(input int c);
        int          n;
        int          p;
        logic        v, b, d;
        logic [11:0] w;
        n = exp_pcs.size();
        if (c < n * GAP) begin
            p = exp_pcs[c / GAP];
            v = (c % GAP == 0);
            b = 1'b1;
            d = 1'b0;
        end else begin
            p = exp_pcs[n - 1];
            v = 1'b0;
            b = 1'b0;
            d = 1'b1;
        end
        w = model_mem[p];
        return {v, b, d, (w[11:8] == OpStore), 4'(p), w, 1'b0};
    endfunction

    // Starts the loaded program and checks every cycle; loads and prog_clr while busy are noise.
    task automatic run_prog(input string tag, input int halt_at, input int freeze_at,
                            input int abort_at);
        int c, fz, total, nbusy;
        build_trace((halt_at >= 0) ? halt_at / GAP : -1);
        nbusy = exp_pcs.size() * GAP;
        total = nbusy + 2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c  = 0;
        fz = 0;
        while (c < total) begin
            chk(tag, obs_vec(), exp_vec(c));
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk_reset({tag, "_async_rst"});
                model_reset();
                bus.load_valid = 1'b0;
                bus.prog_clr   = 1'b0;
                bus.halt_req   = 1'b0;
                return;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = 12'($urandom);
            if (c == freeze_at && fz < 3) begin
                bus.ena      = 1'b0;
                bus.halt_req = 1'b1;
                bus.start    = 1'b1;
                bus.prog_clr = 1'b1;
                fz++;
            end else begin
                bus.ena      = 1'b1;
                bus.halt_req = (c == halt_at);
                bus.start    = 1'b0;
                bus.prog_clr = (c < nbusy) ? 1'($urandom_range(0, 1)) : 1'b0;
                c++;
            end
            tick();
        end
        bus.ena        = 1'b1;
        bus.halt_req   = 1'b0;
        bus.start      = 1'b0;
        bus.prog_clr   = 1'b0;
        bus.load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, halt_at, freeze_at;
        op_pool = '{OpAdd, OpSub, OpStore, OpLoad, OpAnd, OpOr, OpXor, OpNot, OpShl, OpHalt};
        bus.ena        = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.prog_clr   = 1'b0;
        bus.start      = 1'b0;
        bus.halt_req   = 1'b0;
        rst_n          = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_reset("reset_async");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset("reset_state");

        // Start with an empty program is ignored.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk_reset("empty_start");

        // Three-word program with a STORE at pc 2.
        do_load(12'h305);
        do_load(12'h030);
        do_load(12'h207);
        run_prog("prog3", -1, -1, -1);
        do_clear();

        // HALT opcode is issued, then execution stops on it.
        do_load({OpAdd, 8'h12});
        do_load({OpHalt, 8'h34});
        do_load({OpAdd, 8'h56});
        run_prog("halt_op", -1, -1, -1);
        run_prog("restart", -1, -1, -1);
        do_clear();

        // halt_req during the wait of pc 0.
        for (int i = 0; i < 4; i++) do_load(rand_word(1'b0));
        run_prog("halt_req", 1, -1, -1);
        do_clear();

        // Full memory: the 17th load is refused; includes a frozen (ena low) window.
        for (int i = 0; i < DEPTH + 1; i++) do_load(rand_word(1'b0));
        run_prog("full16", -1, 5, -1);
        do_clear();

        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) do_load(rand_word(1'b1));
            if (LOOP) halt_at = $urandom_range(0, 3 * len * GAP);
            else halt_at = ($urandom_range(0, 1) != 0) ? $urandom_range(0, len * GAP + 1) : -1;
            freeze_at = $urandom_range(0, len * GAP);
            run_prog("random", halt_at, freeze_at, -1);
            do_clear();
        end

        if (LOOP) begin
            do_load({OpAdd, 8'h11});
            do_load({OpSub, 8'h22});
            run_prog("loop2", 9, -1, -1);
            do_clear();
        end

        // Reset during the wait of pc 2 aborts at once and clears the program.
        for (int i = 0; i < 4; i++) do_load(rand_word(1'b0));
        run_prog("abort", -1, -1, 5);
        tick();
        tick();
        chk_reset("abort_held");
        rst_n = 1'b1;
        tick();
        chk_reset("post_abort");
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk_reset("post_abort_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, 16, program memory entries (power of two, 2..16).
REQ-002 Parameter ISSUE_GAP, 2, cycles each instruction is held on the issue outputs (>=2).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ena  in  1  high = block enabled; low freezes all state (outputs hold).
REQ-006 load_valid  in  1  program-load write strobe.
REQ-007 load_data  in  12  instruction word {opcode[11:8], data[7:4], addr[3:0]}.
REQ-008 load_ready  out  1  high when a load_valid write is accepted this cycle.
REQ-009 prog_clr  in  1  clears program length to 0 (contents kept).
REQ-010 start  in  1  begin execution at pc 0.
REQ-011 halt_req  in  1  stop after the current instruction completes.
REQ-012 issue_valid  out  1  one-cycle pulse marking a new instruction.
REQ-013 issue_opcode / issue_data / issue_addr  out  4 each  instruction fields to the CPU core.
REQ-014 issue_we  out  1  high when issue_opcode == STORE (4'b0010).
REQ-015 pc  out  4  index of instruction on the issue outputs.
REQ-016 busy  out  1  high in ISSUE or WAIT; done  out  1  high in DONE.

Function
REQ-017 States IDLE, ISSUE, WAIT, DONE; encoding from shared package.
REQ-018 IDLE: load_ready = (wr_ptr < DEPTH); load_valid && load_ready writes mem[wr_ptr], wr_ptr++, prog_len = wr_ptr+1.
REQ-019 IDLE, wr_ptr == DEPTH: load_ready=0, load_valid ignored, no wrap-around.
REQ-020 IDLE: start && !load_valid && prog_len>0 -> ISSUE, pc=0 next cycle; start with prog_len==0 ignored.
REQ-021 IDLE: load_valid && start same cycle -> write accepted, start ignored.
REQ-022 ISSUE: issue_valid=1 one cycle, fields driven from mem[pc]; -> WAIT.
REQ-023 Issue fields and issue_we held stable through ISSUE and all WAIT cycles (ISSUE_GAP cycles total).
REQ-024 WAIT: counts ISSUE_GAP-1 cycles; at expiry: opcode 4'b1111 (HALT), pc==prog_len-1, or halt_req seen since ISSUE -> DONE; else pc++, -> ISSUE.
REQ-025 HALT opcode is issued normally (issue_valid pulses) before DONE.
REQ-026 halt_req in ISSUE/WAIT latched; never truncates the current gap.
REQ-027 DONE: done=1, issue fields hold last instruction, issue_valid=0; start -> ISSUE, pc=0 (program retained); prog_clr -> IDLE with wr_ptr=prog_len=0.
REQ-028 prog_clr in IDLE: wr_ptr=prog_len=0; in ISSUE/WAIT ignored.
REQ-029 load_valid outside IDLE ignored, load_ready=0.
REQ-030 ena low: no state, counter, pointer or memory change; inputs that cycle discarded.

Reset
REQ-031 rst_n low: state IDLE, pc=0, wr_ptr=0, prog_len=0, gap counter 0, halt latch 0, memory all 0.
REQ-032 Reset outputs: issue_valid=0, issue_* =0, issue_we=0, busy=0, done=0, load_ready=1.
REQ-033 Reset mid-execution aborts immediately; no further issue_valid until a new start.

Configuration
REQ-034 Macro INSTR_SEQUENCER_LOOP_EN defined: end-of-program (pc==prog_len-1, non-HALT) wraps pc to 0 and continues ISSUE; only HALT opcode or halt_req reach DONE.
REQ-035 Macro undefined: end-of-program -> DONE per REQ-024; no loop logic compiled.

Structure
REQ-036 Shared package cpu_pkg holds opcode constants (ADD 0000, SUB 0001, STORE 0010, LOAD 0011, AND 0101, OR 0110, XOR 0111, NOT 1000, SHL 1001, HALT 1111), INSTR_W=12, sequencer state typedef.
REQ-037 One sub-module seq_prog_mem: DEPTH x 12 register file, 1 write port, 1 async read port, async active-low reset.

Verification
REQ-038 Load 3 words {0011,0000,0101},{0000,0011,0000},{0010,0000,0111}, start -> issue_valid every 2 cycles, pc 0,1,2, issue_we=1 only at pc 2, done 2 cycles after last pulse.
REQ-039 Load 16 words then 17th load_valid -> load_ready=0 on 17th, prog_len=16, mem[0] unchanged.
REQ-040 Program {ADD,HALT,ADD} -> two issue_valid pulses (pc 0,1), DONE, pc=1 held.
REQ-041 halt_req one cycle during WAIT of pc 0 in 4-word program -> no pc 1 issue, DONE after gap completes.
REQ-042 rst_n low during WAIT of pc 2 -> all outputs to reset values asynchronously; start after release with prog_len 0 ignored.
REQ-043 INSTR_SEQUENCER_LOOP_EN, 2-word program, start -> pc 0,1,0,1... until halt_req, then DONE.
